// File: rtl/axi_burst_addr_gen.sv
// ----------------------------------------------------------------------------
// axi_burst_addr_gen : accepts one AXI-style burst command and emits one
// address beat per handshake (FIXED / INCR / WRAP, illegal -> single err beat).
// Optional feature macro: AXI_BURST_4K_CHECK_EN (INCR 4KB-crossing is illegal)
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module axi_burst_addr_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [2:0]            cmd_size,
  input  logic [1:0]            cmd_burst,
  output logic                  beat_valid,
  input  logic                  beat_ready,
  output logic [ADDR_WIDTH-1:0] beat_addr,
  output logic [LEN_WIDTH-1:0]  beat_idx,
  output logic                  beat_last,
  output logic                  beat_err
);

  localparam int       MAX_SIZE = $clog2(DATA_WIDTH / 8);
  localparam logic [1:0] BT_FIXED = 2'd0;
  localparam logic [1:0] BT_INCR  = 2'd1;
  localparam logic [1:0] BT_WRAP  = 2'd2;
  localparam logic [1:0] BT_RSV   = 2'd3;

  typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] wmask_q, wmask_d;
  logic [LEN_WIDTH-1:0]  idx_q, idx_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            mode_q, mode_d;
  logic                  last_q, last_d;
  logic                  err_q, err_d;

  logic [ADDR_WIDTH-1:0] cmd_step;
  logic [ADDR_WIDTH-1:0] cmd_window;
  logic                  wrap_len_ok;
  logic                  cmd_illegal;
  logic                  cross_4k;
  logic [ADDR_WIDTH-1:0] step_q;
  logic [ADDR_WIDTH-1:0] next_addr;

  assign cmd_step    = ADDR_WIDTH'(1) << cmd_size;
  assign cmd_window  = ADDR_WIDTH'({1'b0, cmd_len} + (LEN_WIDTH+1)'(1)) << cmd_size;
  assign wrap_len_ok = (cmd_len == LEN_WIDTH'(1)) || (cmd_len == LEN_WIDTH'(3)) ||
                       (cmd_len == LEN_WIDTH'(7)) || (cmd_len == LEN_WIDTH'(15));

`ifdef AXI_BURST_4K_CHECK_EN
  localparam int CW = LEN_WIDTH + 16;
  logic [11:0]   step_mask_12;
  logic [CW-1:0] span_end;
  assign step_mask_12 = 12'(cmd_step - ADDR_WIDTH'(1));
  assign span_end     = CW'(cmd_addr[11:0] & ~step_mask_12) +
                        ((CW'(cmd_len) + CW'(1)) << cmd_size);
  assign cross_4k     = (cmd_burst == BT_INCR) && (span_end > CW'(4096));
`else
  assign cross_4k = 1'b0;
`endif

  assign cmd_illegal = (cmd_burst == BT_RSV) || (cmd_size > 3'(MAX_SIZE)) || cross_4k ||
                       ((cmd_burst == BT_WRAP) &&
                        (!wrap_len_ok || ((cmd_addr & (cmd_step - ADDR_WIDTH'(1))) != '0)));

  // Beats after the first are size-aligned, so WRAP can splice the low bits
  // of addr+step into the window base instead of comparing against its end.
  assign step_q = ADDR_WIDTH'(1) << size_q;
  always_comb begin
    next_addr = addr_q;
    case (mode_q)
      BT_FIXED: next_addr = addr_q;
      BT_INCR:  next_addr = (addr_q & ~(step_q - ADDR_WIDTH'(1))) + step_q;
      default:  next_addr = (addr_q & ~wmask_q) | ((addr_q + step_q) & wmask_q);
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wmask_d = wmask_q;
    idx_d   = idx_q;
    len_d   = len_q;
    size_d  = size_q;
    mode_d  = mode_q;
    last_d  = last_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = BURST;
          addr_d  = cmd_addr;
          wmask_d = cmd_window - ADDR_WIDTH'(1);
          idx_d   = '0;
          len_d   = cmd_len;
          size_d  = cmd_size;
          mode_d  = cmd_burst;
          err_d   = cmd_illegal;
          last_d  = cmd_illegal || (cmd_len == '0);
        end
      end
      default: begin
        if (beat_ready) begin
          if (last_q) begin
            state_d = IDLE;
            last_d  = 1'b0;
            err_d   = 1'b0;
          end else begin
            addr_d = next_addr;
            idx_d  = idx_q + LEN_WIDTH'(1);
            last_d = ((idx_q + LEN_WIDTH'(1)) == len_q);
          end
        end
      end
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wmask_q <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      size_q  <= '0;
      mode_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wmask_q <= wmask_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      size_q  <= size_d;
      mode_q  <= mode_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign beat_valid = (state_q == BURST);
  assign beat_addr  = addr_q;
  assign beat_idx   = idx_q;
  assign beat_last  = last_q;
  assign beat_err   = err_q;

endmodule

`default_nettype wire
